// File: rtl/arp_reply_engine.sv
// ARP responder: parses RX ARP payloads, matches target IP against a local table,
// queues replies and streams 60-byte reply frames. Define ARP_PREAMBLE_EN to prefix 55x7 D5.
module arp_reply_engine #(
    parameter int NUM_IP      = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                RstN,
    input  logic                SoFIn,
    input  logic                EoFIn,
    input  logic                ValIn,
    input  logic                ErrIn,
    input  logic [7:0]          DataIn,
    input  logic [47:0]         InnerMAC,
    input  logic [32*NUM_IP-1:0] InnerIP,
    input  logic [NUM_IP-1:0]   IPEnable,
    input  logic                TxReady,
    output logic                ArpReq,
    output logic                FrameOut,
    output logic                ValOut,
    output logic                SoFOut,
    output logic                EoFOut,
    output logic [7:0]          DataOut,
    output logic [15:0]         DropCount
);

    localparam int KW = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
`ifdef ARP_PREAMBLE_EN
    localparam int PRE_LEN = 8;
`else
    localparam int PRE_LEN = 0;
`endif
    localparam int FRAME_LEN = 60 + PRE_LEN;

    typedef struct packed {
        logic [47:0]   mac;
        logic [31:0]   ip;
        logic [KW-1:0] k;
    } entry_t;

    typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_FIELDS, RX_SKIP} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    // ARP header bytes 0..7 with a selectable opcode low byte
    function automatic logic [7:0] hdr_byte(input logic [2:0] n, input logic [7:0] op_lo);
        case (n)
            3'd1:    return 8'h01;
            3'd2:    return 8'h08;
            3'd4:    return 8'h06;
            3'd5:    return 8'h04;
            3'd7:    return op_lo;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] n);
        logic [47:0] s;
        s = m >> {n, 3'b000};
        return s[7:0];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] n);
        logic [31:0] s;
        s = ip >> {n, 3'b000};
        return s[7:0];
    endfunction

    rx_state_e   rx_state_q, rx_state_d, rx_eff;
    logic [4:0]  idx_q, idx_d, cur_idx;
    logic [47:0] smac_q, smac_d;
    logic [31:0] sip_q, sip_d, tip_q, tip_d;
    logic        acc_q, acc_d;
    entry_t      push_q, push_d;
    logic        hit;
    logic [KW-1:0] hit_k;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_eff     = rx_state_q;
        idx_d      = idx_q;
        cur_idx    = idx_q;
        smac_d     = smac_q;
        sip_d      = sip_q;
        tip_d      = tip_q;
        acc_d      = 1'b0;
        push_d     = push_q;
        hit        = 1'b0;
        hit_k      = '0;
        if (ValIn && (SoFIn || rx_state_q != RX_IDLE)) begin
            if (SoFIn) begin
                rx_eff  = RX_HDR;
                cur_idx = 5'd0;
            end
            idx_d      = (cur_idx >= 5'd28) ? 5'd28 : cur_idx + 5'd1;
            rx_state_d = rx_eff;
            if (rx_eff == RX_HDR) begin
                if (DataIn != hdr_byte(cur_idx[2:0], 8'h01)) rx_state_d = RX_SKIP;
                else if (cur_idx == 5'd7)                    rx_state_d = RX_FIELDS;
            end
            if (rx_eff == RX_FIELDS) begin
                if (cur_idx >= 5'd8  && cur_idx <= 5'd13) smac_d = {smac_q[39:0], DataIn};
                if (cur_idx >= 5'd14 && cur_idx <= 5'd17) sip_d  = {sip_q[23:0], DataIn};
                if (cur_idx >= 5'd24 && cur_idx <= 5'd27) tip_d  = {tip_q[23:0], DataIn};
            end
            // Table is sampled on the EoF byte, which may itself carry the last target IP byte
            for (int k = 0; k < NUM_IP; k++) begin
                if (!hit && IPEnable[k] && InnerIP[32*k +: 32] == tip_d) begin
                    hit   = 1'b1;
                    hit_k = KW'(k);
                end
            end
            if (EoFIn) begin
                rx_state_d = RX_IDLE;
                acc_d      = (rx_eff == RX_FIELDS) && (idx_d == 5'd28) && !ErrIn && hit;
                push_d     = '{mac: smac_d, ip: sip_d, k: hit_k};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            rx_state_q <= RX_IDLE;
            idx_q      <= '0;
            smac_q     <= '0;
            sip_q      <= '0;
            tip_q      <= '0;
            acc_q      <= 1'b0;
            push_q     <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            idx_q      <= idx_d;
            smac_q     <= smac_d;
            sip_q      <= sip_d;
            tip_q      <= tip_d;
            acc_q      <= acc_d;
            push_q     <= push_d;
        end
    end

    entry_t        mem_q [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   drop_q;
    logic          pop, push_ok, drop;
    entry_t        head;

    assign head    = mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a full queue still takes the push
    assign push_ok = acc_q && ((count_q != CW'(QUEUE_DEPTH)) || pop);
    assign drop    = acc_q && !push_ok;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

    tx_state_e   tx_state_q, tx_state_d;
    logic [6:0]  cnt_q, cnt_d, b;
    logic [7:0]  tx_byte;
    logic [31:0] lip;
    logic        fire;

    assign fire = (tx_state_q == TX_SEND) && TxReady;

    always_comb begin
        tx_state_d = tx_state_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (count_q != '0) begin
                    tx_state_d = TX_SEND;
                    cnt_d      = '0;
                end
            end
            TX_SEND: begin
                if (fire) begin
                    if (cnt_q == 7'(FRAME_LEN - 1)) begin
                        tx_state_d = TX_IDLE;
                        pop        = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            tx_state_q <= TX_IDLE;
            cnt_q      <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        lip = '0;
        for (int k = 0; k < NUM_IP; k++)
            if (head.k == KW'(k)) lip = InnerIP[32*k +: 32];
    end

    // b is the reply byte index after any preamble; it wraps high during the preamble
    always_comb begin
        tx_byte = 8'h00;
        b       = cnt_q - 7'(PRE_LEN);
        if (b < 7'd6)       tx_byte = mac_byte(head.mac, 3'(7'd5 - b));
        else if (b < 7'd12) tx_byte = mac_byte(InnerMAC, 3'(7'd11 - b));
        else if (b == 7'd12) tx_byte = 8'h08;
        else if (b == 7'd13) tx_byte = 8'h06;
        else if (b < 7'd22) tx_byte = hdr_byte(3'(b - 7'd14), 8'h02);
        else if (b < 7'd28) tx_byte = mac_byte(InnerMAC, 3'(7'd27 - b));
        else if (b < 7'd32) tx_byte = ip_byte(lip, 2'(7'd31 - b));
        else if (b < 7'd38) tx_byte = mac_byte(head.mac, 3'(7'd37 - b));
        else if (b < 7'd42) tx_byte = ip_byte(head.ip, 2'(7'd41 - b));
`ifdef ARP_PREAMBLE_EN
        if (cnt_q < 7'd7)       tx_byte = 8'h55;
        else if (cnt_q == 7'd7) tx_byte = 8'hD5;
`endif
    end

    assign ValOut    = (tx_state_q == TX_SEND);
    assign FrameOut  = ValOut;
    assign SoFOut    = ValOut && (cnt_q == 7'd0);
    assign EoFOut    = ValOut && (cnt_q == 7'(FRAME_LEN - 1));
    assign DataOut   = ValOut ? tx_byte : 8'h00;
    assign ArpReq    = (count_q != '0);
    assign DropCount = drop_q;

endmodule

// File: tb/tb_arp_reply_engine.sv
// Scoreboard bench for arp_reply_engine: stimulus pushes expected reply bytes,
// a negedge monitor pops and compares every accepted TX byte.
module tb_arp_reply_engine;
    localparam int NUM_IP = 4;
    localparam int QD     = 4;
    localparam logic [47:0] MYMAC = 48'h000A35010203;
`ifdef ARP_PREAMBLE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic Clk = 1'b0, RstN = 1'b0;
    logic SoFIn = 1'b0, EoFIn = 1'b0, ValIn = 1'b0, ErrIn = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic [NUM_IP-1:0] IPEnable = '1;
    logic TxReady = 1'b0;
    logic [32*NUM_IP-1:0] InnerIP;
    logic ArpReq, FrameOut, ValOut, SoFOut, EoFOut;
    logic [7:0] DataOut;
    logic [15:0] DropCount;
    logic [31:0] ip_tab [NUM_IP];

    int pass_cnt = 0, tot_cnt = 0;
    int tx_mode = 0;
    logic [9:0] exp_q [$];
    bit arp_seen = 1'b0;

    assign InnerIP = {ip_tab[3], ip_tab[2], ip_tab[1], ip_tab[0]};

    arp_reply_engine #(.NUM_IP(NUM_IP), .QUEUE_DEPTH(QD)) dut (
        .Clk(Clk), .RstN(RstN), .SoFIn(SoFIn), .EoFIn(EoFIn), .ValIn(ValIn), .ErrIn(ErrIn),
        .DataIn(DataIn), .InnerMAC(MYMAC), .InnerIP(InnerIP), .IPEnable(IPEnable),
        .TxReady(TxReady), .ArpReq(ArpReq), .FrameOut(FrameOut), .ValOut(ValOut),
        .SoFOut(SoFOut), .EoFOut(EoFOut), .DataOut(DataOut), .DropCount(DropCount)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #1;
        case (tx_mode)
            0:       TxReady = 1'b0;
            1:       TxReady = 1'b1;
            default: TxReady = ~TxReady;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare accepted bytes against the scoreboard and check stall stability
    logic [9:0] stall_val = '0;
    bit stall_prev = 1'b0;
    always @(negedge Clk) begin
        logic [9:0] got;
        if (ArpReq) arp_seen = 1'b1;
        if (!RstN) begin
            stall_prev = 1'b0;
        end else if (ValOut) begin
            got = {SoFOut, EoFOut, DataOut};
            if (stall_prev) check("stall_hold", {22'd0, got}, {22'd0, stall_val});
            if (TxReady) begin
                if (exp_q.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_byte: got %h expected none", got);
                end else begin
                    check("tx_byte", {22'd0, got}, {22'd0, exp_q.pop_front()});
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_val  = got;
            end
        end else begin
            if (stall_prev) check("stall_valid", {31'd0, ValOut}, 32'd1);
            stall_prev = 1'b0;
        end
    end

    task automatic exp_reply(input logic [47:0] smac, input logic [31:0] sip, input int k);
        logic [7:0] b [60];
        logic [63:0] op;
        logic sof;
        op = 64'h0001080006040002;
        for (int i = 0; i < 6; i++) begin
            b[i]      = smac[47-8*i -: 8];
            b[6+i]    = MYMAC[47-8*i -: 8];
            b[22+i]   = MYMAC[47-8*i -: 8];
            b[32+i]   = smac[47-8*i -: 8];
        end
        b[12] = 8'h08;
        b[13] = 8'h06;
        for (int i = 0; i < 8; i++) b[14+i] = op[63-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            b[28+i] = ip_tab[k][31-8*i -: 8];
            b[38+i] = sip[31-8*i -: 8];
        end
        for (int i = 42; i < 60; i++) b[i] = 8'h00;
        if (PRE) begin
            for (int i = 0; i < 7; i++) begin
                sof = (i == 0);
                exp_q.push_back({sof, 1'b0, 8'h55});
            end
            exp_q.push_back({2'b00, 8'hD5});
        end
        for (int i = 0; i < 60; i++) begin
            sof = (i == 0) && !PRE;
            exp_q.push_back({sof, (i == 59), b[i]});
        end
    endtask

    // Drives one payload, one byte per cycle; leaves the last byte on the bus
    task automatic send_req(input logic [31:0] tip, input logic [47:0] smac, input logic [31:0] sip,
                            input logic [7:0] op, input logic err, input int len);
        logic [7:0] p [64];
        logic [63:0] h;
        h = {56'h00010800060400, op};
        for (int i = 0; i < 64; i++) p[i] = 8'h00;
        for (int i = 0; i < 8; i++) p[i] = h[63-8*i -: 8];
        for (int i = 0; i < 6; i++) p[8+i] = smac[47-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            p[14+i] = sip[31-8*i -: 8];
            p[24+i] = tip[31-8*i -: 8];
        end
        for (int i = 0; i < len; i++) begin
            ValIn  = 1'b1;
            SoFIn  = (i == 0);
            EoFIn  = (i == len - 1);
            ErrIn  = err && (i == len - 1);
            DataIn = p[i];
            @(posedge Clk); #1;
        end
    endtask

    task automatic rx_idle();
        ValIn = 1'b0; SoFIn = 1'b0; EoFIn = 1'b0; ErrIn = 1'b0; DataIn = 8'h00;
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(posedge Clk);
        check("drain", exp_q.size(), 0);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic expect_silent(input string name);
        arp_seen = 1'b0;
        repeat (40) @(posedge Clk);
        #1;
        check(name, {31'd0, arp_seen}, 32'd0);
    endtask

    localparam logic [47:0] SMAC = 48'h021122334455;
    localparam logic [31:0] SIP  = 32'hC0A80101;
    localparam logic [31:0] TIP2 = 32'hC0A8010A;

    initial begin
        ip_tab[0] = 32'h0A000001;
        ip_tab[1] = 32'h0A000002;
        ip_tab[2] = TIP2;
        ip_tab[3] = 32'hAC100005;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outs", {25'd0, ValOut, SoFOut, EoFOut, FrameOut, ArpReq, 2'd0}, 32'd0);
        check("reset_data", {24'd0, DataOut}, 32'd0);
        check("reset_drop", {16'd0, DropCount}, 32'd0);
        RstN = 1'b1;
        tx_mode = 1;
        @(posedge Clk); #1;

        // Basic request for entry 2, padded payload
        exp_reply(SMAC, SIP, 2);
        send_req(TIP2, SMAC, SIP, 8'h01, 1'b0, 30);
        rx_idle();
        check("arpreq_t1", {31'd0, ArpReq}, 32'd0);
        @(posedge Clk); #1;
        check("arpreq_t2", {31'd0, ArpReq}, 32'd1);
        wait_drain(200);
        check("arpreq_fall", {31'd0, ArpReq}, 32'd0);
        check("idle_val", {31'd0, ValOut}, 32'd0);

        // Rejections
        IPEnable = 4'b1011;
        send_req(TIP2, SMAC, SIP, 8'h01, 1'b0, 30);
        rx_idle();
        IPEnable = '1;
        expect_silent("rej_ipen");
        send_req(TIP2, SMAC, SIP, 8'h01, 1'b1, 30);
        rx_idle();
        expect_silent("rej_err");
        send_req(TIP2, SMAC, SIP, 8'h02, 1'b0, 30);
        rx_idle();
        expect_silent("rej_opcode");
        send_req(TIP2, SMAC, SIP, 8'h01, 1'b0, 20);
        rx_idle();
        expect_silent("rej_short");

        // Entry 0 with minimum-size Ethernet padding
        exp_reply(48'h02AABBCCDDEE, 32'h0A000063, 0);
        send_req(32'h0A000001, 48'h02AABBCCDDEE, 32'h0A000063, 8'h01, 1'b0, 46);
        rx_idle();
        wait_drain(200);

        // Overflow: QD+2 back-to-back requests while stalled
        tx_mode = 0;
        @(posedge Clk); #1;
        for (int i = 0; i < QD; i++)
            exp_reply({40'h0200000000, 8'(i)}, 32'h0A000064 + i, 1);
        for (int i = 0; i < QD + 2; i++)
            send_req(32'h0A000002, {40'h0200000000, 8'(i)}, 32'h0A000064 + i, 8'h01, 1'b0, 28);
        rx_idle();
        repeat (3) @(posedge Clk);
        #1;
        check("drop_count", {16'd0, DropCount}, 32'd2);
        check("arpreq_full", {31'd0, ArpReq}, 32'd1);
        check("stalled_first", {21'd0, ValOut, SoFOut, EoFOut, DataOut}, {21'd0, 1'b1, exp_q[0]});
        tx_mode = 1;
        wait_drain(800);

        // Stalled every other cycle: same byte stream expected
        tx_mode = 2;
        exp_reply(48'h0266778899AA, 32'h0A0000C8, 3);
        send_req(32'hAC100005, 48'h0266778899AA, 32'h0A0000C8, 8'h01, 1'b0, 28);
        rx_idle();
        wait_drain(400);

        // Reset at TX byte 30
        tx_mode = 1;
        @(posedge Clk); #1;
        exp_reply(SMAC, SIP, 2);
        send_req(TIP2, SMAC, SIP, 8'h01, 1'b0, 28);
        rx_idle();
        for (int i = 0; i < 100 && !ValOut; i++) begin
            @(posedge Clk); #1;
        end
        check("tx_start", {31'd0, ValOut}, 32'd1);
        repeat (30) begin
            @(posedge Clk); #1;
        end
        exp_q.delete();
        RstN = 1'b0;
        @(posedge Clk); #1;
        RstN = 1'b1;
        check("rst_outs", {25'd0, ValOut, SoFOut, EoFOut, FrameOut, ArpReq, 2'd0}, 32'd0);
        check("rst_data", {24'd0, DataOut}, 32'd0);
        check("rst_drop", {16'd0, DropCount}, 32'd0);
        expect_silent("rst_queue_empty");
        exp_reply(SMAC, SIP, 2);
        send_req(TIP2, SMAC, SIP, 8'h01, 1'b0, 30);
        rx_idle();
        wait_drain(200);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
